tdc_meas_ctrl: RTL and testbench

Measurement sequencer for the Chrono32C start/stop front end. It arms the TDC, waits for the start pulse, and collects first hits on the 8 stop channels, with a programmable cycle timeout. It then presents the result to the readout logic through a level interrupt with acknowledge. Before re-arming, it waits for all start/stop inputs to be quiet for a fixed number of cycles.

---
 rtl/tdc_meas_ctrl_if.sv | 32 +++
 rtl/tdc_meas_ctrl.sv | 137 +++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_meas_ctrl_if.sv
// tdc_meas_ctrl_if: control/status bundle between the readout logic (master)
// and the tdc_meas_ctrl measurement sequencer (slave).
interface tdc_meas_ctrl_if #(
    parameter int N_STOP = 8,
    parameter int TW     = 16
);
    logic              arm;
    logic              abort;
    logic [TW-1:0]     timeout;
    logic [N_STOP-1:0] ch_en;
    logic              startpulse;
    logic [N_STOP-1:0] stoppulse;
    logic              rd_ack;
    logic              tdc_en;
    logic              busy;
    logic              irq;
    logic [N_STOP-1:0] hit_mask;
    logic              timed_out;
    logic              early_stop;
    logic [TW-1:0]     elapsed;
    logic [2:0]        state;

    modport master (
        output arm, abort, timeout, ch_en, startpulse, stoppulse, rd_ack,
        input  tdc_en, busy, irq, hit_mask, timed_out, early_stop, elapsed, state
    );

    modport slave (
        input  arm, abort, timeout, ch_en, startpulse, stoppulse, rd_ack,
        output tdc_en, busy, irq, hit_mask, timed_out, early_stop, elapsed, state
    );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: arms the TDC, collects first stop hits after start (optional cycle timeout),
// hands results over via irq/rd_ack, then waits for quiet inputs before re-arming.
module tdc_meas_ctrl #(
    parameter int N_STOP    = 8,
    parameter int TW        = 16,
    parameter int QUIET_CYC = 60
) (
    input logic             clk,
    input logic             res,
    tdc_meas_ctrl_if.slave  bus
);
    localparam int QW = $clog2(QUIET_CYC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_MEASURE = 3'd2,
        S_READOUT = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic              r_start_prev;
    logic [N_STOP-1:0] r_stop_prev;
    logic [N_STOP-1:0] r_ch_en, w_ch_en;
    logic [N_STOP-1:0] r_hit_mask, w_hit_mask;
    logic              r_timed_out, w_timed_out;
    logic              r_early_stop, w_early_stop;
    logic [TW-1:0]     r_elapsed, w_elapsed;
    logic [QW-1:0]     r_quiet, w_quiet;
    logic              r_tdc_en, r_busy, r_irq;

    logic              w_start_edge;
    logic [N_STOP-1:0] w_stop_hit;
    logic              w_quiet_now;
    logic [TW-1:0]     w_elapsed_inc;
    logic              w_abort;

    assign w_start_edge  = bus.startpulse & ~r_start_prev;
    assign w_stop_hit    = bus.stoppulse & ~r_stop_prev & r_ch_en;
    assign w_quiet_now   = ~bus.startpulse & ~|bus.stoppulse;
    assign w_elapsed_inc = &r_elapsed ? r_elapsed : r_elapsed + TW'(1);
    assign w_abort       = bus.abort && (r_state inside {S_ARMED, S_MEASURE, S_READOUT});

    always_comb begin
        w_next       = r_state;
        w_ch_en      = r_ch_en;
        w_hit_mask   = r_hit_mask;
        w_timed_out  = r_timed_out;
        w_early_stop = r_early_stop;
        w_elapsed    = r_elapsed;
        w_quiet      = '0;
        case (r_state)
            S_IDLE: if (bus.arm) begin
                w_next       = S_ARMED;
                w_ch_en      = bus.ch_en;
                w_hit_mask   = '0;
                w_timed_out  = 1'b0;
                w_early_stop = 1'b0;
                w_elapsed    = '0;
            end
            S_ARMED: if (w_start_edge) begin
                w_next     = S_MEASURE;
                w_elapsed  = '0;
                w_hit_mask = r_hit_mask | w_stop_hit;
            end else if (|w_stop_hit) begin
                w_early_stop = 1'b1;
            end
            S_MEASURE: begin
                w_hit_mask = r_hit_mask | w_stop_hit;
                // all-hit is tested first so it wins over a timeout in the same cycle
                if ((w_hit_mask & r_ch_en) == r_ch_en) begin
                    w_next    = S_READOUT;
                    w_elapsed = w_elapsed_inc;
                end else if (bus.timeout != '0 && r_elapsed == bus.timeout) begin
                    w_next      = S_READOUT;
                    w_timed_out = 1'b1;
                end else begin
                    w_elapsed = w_elapsed_inc;
                end
            end
            S_READOUT: w_next = bus.rd_ack ? S_RECOVER : S_READOUT;
            S_RECOVER: if (w_quiet_now) begin
                w_next  = (r_quiet == QW'(QUIET_CYC - 1)) ? S_IDLE : S_RECOVER;
                w_quiet = (r_quiet == QW'(QUIET_CYC - 1)) ? '0 : r_quiet + QW'(1);
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next       = S_RECOVER;
            w_hit_mask   = r_hit_mask;
            w_timed_out  = r_timed_out;
            w_early_stop = r_early_stop;
            w_elapsed    = r_elapsed;
        end
    end

    // previous-value registers reset high so inputs already high at release give no edge
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b1;
            r_stop_prev  <= '1;
            r_ch_en      <= '0;
            r_hit_mask   <= '0;
            r_timed_out  <= 1'b0;
            r_early_stop <= 1'b0;
            r_elapsed    <= '0;
            r_quiet      <= '0;
            r_tdc_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_prev <= bus.startpulse;
            r_stop_prev  <= bus.stoppulse;
            r_ch_en      <= w_ch_en;
            r_hit_mask   <= w_hit_mask;
            r_timed_out  <= w_timed_out;
            r_early_stop <= w_early_stop;
            r_elapsed    <= w_elapsed;
            r_quiet      <= w_quiet;
            r_tdc_en     <= (w_next == S_ARMED) || (w_next == S_MEASURE);
            r_busy       <= w_next != S_IDLE;
            r_irq        <= w_next == S_READOUT;
        end
    end

    assign bus.tdc_en     = r_tdc_en;
    assign bus.busy       = r_busy;
    assign bus.irq        = r_irq;
    assign bus.hit_mask   = r_hit_mask;
    assign bus.timed_out  = r_timed_out;
    assign bus.early_stop = r_early_stop;
    assign bus.elapsed    = r_elapsed;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: table of measurement scenarios plus randomized scenarios checked against
// an offset-arithmetic reference model, and hand sequences for abort, recovery and reset.
module tb_tdc_meas_ctrl;
    localparam logic [7:0] X = 8'hFF;

    typedef struct packed {
        logic [7:0]      en;
        logic [15:0]     tmo;
        logic [7:0]      pre;
        logic [7:0]      rep;
        logic [7:0][7:0] off;
        logic [7:0]      mask;
        logic            to;
        logic [15:0]     el;
    } vec_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[9];

    tdc_meas_ctrl_if #(.N_STOP(8), .TW(16)) bus ();
    tdc_meas_ctrl #(.N_STOP(8), .TW(16), .QUIET_CYC(60)) dut (.clk(clk), .res(res), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] stops_at(input vec_t v, input int d);
        logic [7:0] s;
        s = '0;
        for (int c = 0; c < 8; c++)
            s[c] = v.off[c] != X && (d == int'(v.off[c]) || (v.rep[c] && d == int'(v.off[c]) + 3));
        return s;
    endfunction

    // Outcome from first-hit offsets (edges after the start edge): measurement ends at the latest
    // enabled first hit, unless that lies beyond the timeout edge T+1, which then ends it instead.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   last;
        bit   all;
        r = v;
        last = 0;
        all = 1;
        for (int c = 0; c < 8; c++)
            if (v.en[c]) begin
                if (v.off[c] == X) all = 0;
                else if (int'(v.off[c]) > last) last = int'(v.off[c]);
            end
        if (all && (v.tmo == 0 || last <= int'(v.tmo) + 1)) begin
            r.mask = v.en;
            r.to   = 1'b0;
            r.el   = 16'(last < 1 ? 1 : last);
        end else begin
            r.to   = 1'b1;
            r.el   = v.tmo;
            r.mask = '0;
            for (int c = 0; c < 8; c++)
                r.mask[c] = v.en[c] && v.off[c] != X && int'(v.off[c]) <= int'(v.tmo) + 1;
        end
        return r;
    endfunction

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.state != 3'd0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic run_meas(input vec_t v, input bit hold);
        int  d, n;
        bit  got;
        bus.ch_en = v.en;
        bus.timeout = v.tmo;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("armed_state", bus.state, 3'd1);
        chk("armed_tdc_en", {bus.tdc_en, bus.busy, bus.irq}, 3'b110);
        chk("armed_clear", {bus.hit_mask, bus.timed_out, bus.early_stop, bus.elapsed}, 0);
        bus.stoppulse = v.pre;
        tick();
        bus.stoppulse = '0;
        tick();
        chk("early_stop", bus.early_stop, |(v.pre & v.en));
        bus.startpulse = 1'b1;
        bus.stoppulse = stops_at(v, 0);
        tick();
        bus.startpulse = 1'b0;
        chk("measure_state", bus.state, 3'd2);
        d = 0;
        got = 0;
        while (!got && d < 400) begin
            d++;
            bus.stoppulse = stops_at(v, d);
            tick();
            got = bus.irq;
        end
        bus.stoppulse = '0;
        chk("irq_cycle", d, 32'(v.el) + 32'(v.to));
        chk("hit_mask", bus.hit_mask, v.mask);
        chk("timed_out", bus.timed_out, v.to);
        chk("elapsed", bus.elapsed, v.el);
        chk("readout_out", {bus.state, bus.tdc_en, bus.busy}, {3'd3, 2'b01});
        tick();
        chk("readout_hold", {bus.irq, bus.hit_mask, bus.elapsed}, {1'b1, v.mask, v.el});
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        chk("recover_state", {bus.state, bus.irq}, {3'd4, 1'b0});
        if (hold) begin
            repeat (20) tick();
            bus.stoppulse[3] = 1'b1;
            repeat (10) tick();
            chk("hold_still_recover", bus.state, 3'd4);
            bus.stoppulse = '0;
        end
        wait_idle(n);
        chk("quiet_dwell", n, 60);
        chk("idle_results", {bus.hit_mask, bus.timed_out, bus.elapsed, bus.busy}, {v.mask, v.to, v.el, 1'b0});
    endtask

    initial begin
        bit   seen;
        int   n;
        vec_t v;
        //           en     tmo    pre    rep    off ch7..ch0                                mask   to    el
        tbl[0] = {8'h0F, 16'd100, 8'h00, 8'h01, {X, X, X, X, 8'd20, 8'd12, 8'd10, 8'd5},   8'h0F, 1'b0, 16'd20};
        tbl[1] = {8'hFF, 16'd50,  8'h00, 8'h00, {X, 8'd30, X, X, X, X, 8'd7, X},           8'h42, 1'b1, 16'd50};
        tbl[2] = {8'h01, 16'd0,   8'h00, 8'h00, {X, X, X, X, X, X, X, 8'd0},               8'h01, 1'b0, 16'd1};
        tbl[3] = {8'h03, 16'd0,   8'h80, 8'h00, {8'd3, X, X, X, X, X, 8'd9, 8'd4},         8'h03, 1'b0, 16'd9};
        tbl[4] = {8'h05, 16'd10,  8'h00, 8'h00, {X, X, X, X, X, 8'd11, X, 8'd2},           8'h05, 1'b0, 16'd11};
        tbl[5] = {8'h00, 16'd5,   8'h00, 8'h00, {X, X, X, X, X, X, X, X},                  8'h00, 1'b0, 16'd1};
        tbl[6] = {8'h80, 16'd1,   8'h00, 8'h00, {X, X, X, X, X, X, X, X},                  8'h00, 1'b1, 16'd1};
        tbl[7] = {8'h03, 16'd3,   8'h00, 8'h00, {X, X, X, X, X, X, X, 8'd4},               8'h01, 1'b1, 16'd3};
        tbl[8] = {8'h0F, 16'd8,   8'h04, 8'h00, {X, X, X, X, 8'd3, X, 8'd2, 8'd0},         8'h0B, 1'b1, 16'd8};

        bus.arm = 0; bus.abort = 0; bus.timeout = '0; bus.ch_en = '0;
        bus.startpulse = 0; bus.stoppulse = '0; bus.rd_ack = 0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        chk("reset_outputs", {bus.state, bus.tdc_en, bus.busy, bus.irq, bus.hit_mask,
                              bus.timed_out, bus.early_stop, bus.elapsed}, 0);

        for (int i = 0; i < 9; i++) run_meas(tbl[i], 1'b0);
        run_meas(tbl[2], 1'b1);

        for (int i = 0; i < 40; i++) begin
            v.en  = 8'($urandom);
            v.tmo = 16'($urandom_range(0, 40));
            v.pre = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            v.rep = 8'($urandom);
            for (int c = 0; c < 8; c++)
                v.off[c] = (v.tmo != 0 && $urandom_range(0, 3) == 0) ? X : 8'($urandom_range(0, 45));
            run_meas(model(v), 1'b0);
        end

        // abort mid-measurement: results held, irq never raised, abort ignored in RECOVER
        bus.ch_en = 8'hFF;
        bus.timeout = '0;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        bus.startpulse = 1'b1;
        tick();
        bus.startpulse = 1'b0;
        seen = 0;
        for (int d = 1; d <= 4; d++) begin
            bus.stoppulse = (d == 2) ? 8'h01 : 8'h00;
            bus.abort = (d == 4);
            tick();
            seen |= bus.irq;
        end
        bus.stoppulse = '0;
        chk("abort_state", {bus.state, bus.tdc_en, bus.irq}, {3'd4, 2'b00});
        chk("abort_no_irq", seen, 0);
        chk("abort_held", {bus.hit_mask, bus.timed_out, bus.elapsed}, {8'h01, 1'b0, 16'd3});
        wait_idle(n);
        bus.abort = 1'b0;
        chk("abort_quiet_dwell", n, 60);

        // reset mid-measurement, with inputs held high through the release
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        bus.startpulse = 1'b1;
        tick();
        bus.startpulse = 1'b0;
        repeat (3) tick();
        chk("pre_reset_measure", {bus.state, bus.tdc_en}, {3'd2, 1'b1});
        #2 res = 1'b1;
        #1;
        chk("async_reset", {bus.state, bus.tdc_en, bus.busy, bus.irq, bus.hit_mask,
                            bus.timed_out, bus.early_stop, bus.elapsed}, 0);
        bus.startpulse = 1'b1;
        bus.stoppulse = 8'hFF;
        tick();
        res = 1'b0;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        repeat (3) tick();
        chk("no_edge_after_reset", {bus.state, bus.early_stop, bus.hit_mask}, {3'd1, 1'b0, 8'h00});
        bus.startpulse = 1'b0;
        bus.stoppulse = '0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("armed_abort", {bus.state, bus.tdc_en}, {3'd4, 1'b0});
        wait_idle(n);
        chk("armed_abort_dwell", n, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
